pwm_ctrl: RTL and testbench
===========================

Name: pwm_ctrl

Overview:
Wishbone-slave controller that configures and sequences a bank of NCH PWM channels on a shared prescaled timebase. It sits inside user_project on the Caravel management Wishbone bus (wb_clk_i domain). Its outputs drive io_out/io_oeb bits and a user_irq line. Duty and period writes are double-buffered and take effect only at a period boundary, so firmware never causes glitched output pulses.

Parameters:
NCH, 4, number of PWM channels (1..8)
CW, 16, counter/period/duty width in bits (8..16)
BASE_ADDR, 32'h3000_0000, Wishbone base address; the block decodes wbs_adr_i[31:8] == BASE_ADDR[31:8]

Ports:
wb_clk_i  in  1  sole clock
wb_rst_i  in  1  reset, synchronous, active-high
wbs_cyc_i  in  1  Wishbone cycle
wbs_stb_i  in  1  Wishbone strobe
wbs_we_i  in  1  write enable
wbs_sel_i  in  4  byte enables
wbs_adr_i  in  32  byte address
wbs_dat_i  in  32  write data
wbs_ack_o  out  1  acknowledge
wbs_dat_o  out  32  read data
pwm_o  out  NCH  PWM outputs
pwm_oeb  out  NCH  pad output-enable-bar; equals ~EN replicated across all channels
irq_o  out  1  period-end interrupt

Behaviour:
- Reset: wb_rst_i is synchronous and active-high. All registers, shadow registers and counters clear to 0. wbs_ack_o=0, wbs_dat_o=0, pwm_o=0, pwm_oeb=all 1, irq_o=0.
- Register map, word offsets taken from adr[7:2]:
  - 0x00 CTRL: [0] EN; [1] IRQ_EN; [2] UPD. Writing 1 to UPD requests a shadow load; hardware self-clears it.
  - 0x04 PRESC: [15:0] prescaler divide minus one.
  - 0x08 PERIOD: [CW-1:0], shadow.
  - 0x0C STATUS: [0] PEND, sticky period-end flag, write-1-to-clear; [1] UPD pending, read-only.
  - 0x10+4*i DUTY[i]: [CW-1:0], shadow.
  - Unmapped offsets read 0, ignore writes, and still ack.
- Bus handshake:
  - ack is registered and asserted 1 cycle after cyc&stb&match, provided ack is currently low.
  - ack is high for exactly 1 cycle, so there are no back-to-back acks and one access completes per 2 cycles minimum.
  - wbs_dat_o is registered alongside ack and returns to 0 when ack=0.
  - Writes honour wbs_sel_i per byte.
  - Address mismatch produces no ack and no side effect.
- Timebase:
  - pcnt counts 0..PRESC; tick when pcnt==PRESC, then pcnt returns to 0.
  - On each tick: if cnt==per_act, cnt<=0 and a period-end event fires; otherwise cnt<=cnt+1.
  - Period length = (per_act+1)*(PRESC+1) cycles.
- Output: pwm_o[i] = EN & (cnt < duty_act[i]).
  - duty 0 gives constant low.
  - duty > per_act gives constant high.
- Shadow load:
  - On a period-end event with UPD=1, per_act and duty_act[] copy from the shadow registers, and UPD clears in the same cycle.
  - While EN=0: pcnt=cnt=0, pwm_o=0, and the active copies track the shadows every cycle, so the first period after enable uses the programmed values.
- Enable:
  - An EN 0->1 write makes the counter start at 0 on the following cycle.
  - pwm_o goes high that cycle if duty_act>0.
  - An EN 1->0 write forces pwm_o=0 and the counters to 0 on the next cycle, mid-period allowed.
- Events:
  - A period-end event sets PEND.
  - irq_o = PEND & IRQ_EN, registered.
- Simultaneity rules:
  - A CTRL write setting UPD in the same cycle as a period-end event: UPD remains 1 and the load happens at the next period end.
  - STATUS W1C in the same cycle as a period-end event: set wins, PEND=1.
  - A PRESC write takes effect immediately. If the new PRESC < pcnt, pcnt wraps at the counter's natural overflow; firmware must write PRESC only while EN=0 (documented).
- Reset mid-operation: all state returns to reset values on the next edge; no pending update survives.

Decomposition:
- Package pwm_ctrl_pkg:
  - register offset constants (CTRL, PRESC, PERIOD, STATUS, DUTY0);
  - CTRL/STATUS bit-index constants;
  - reset-value constants.
- Sub-module pwm_timebase: prescaler plus period counter.
  - Inputs: en, presc, per_act.
  - Outputs: cnt, period_end.
- pwm_ctrl keeps the Wishbone decode, the registers, the shadow logic and the per-channel compares.

Test Plan:
- Reset then read all registers: every read returns 0, ack arrives exactly 1 cycle after stb, pwm_oeb=4'hF, pwm_o=0.
- PRESC=0, PERIOD=9, DUTY0=3, DUTY1=0, DUTY2=10, EN=1: pwm_o[0] high 3 of every 10 cycles, pwm_o[1] always 0, pwm_o[2] always 1.
- Running with PERIOD=9, DUTY0=3; write DUTY0=7 and set UPD mid-period: old 3-cycle duty completes the current period, 7-cycle duty starts at cnt=0 of the next period, STATUS[1] reads 1 until the load then 0.
- PRESC=2, PERIOD=4, IRQ_EN=1: irq_o first asserts after 15 cycles of enable. Write STATUS=1 → irq_o drops. Issue the W1C exactly on a period-end cycle → PEND stays 1.
- Byte-enable and decode: write 32'hAABBCCDD to DUTY0 with sel=4'b0001 → reads 32'h000000DD. Access at BASE_ADDR+0x100 → no ack.
- Assert wb_rst_i mid-period with UPD pending: next cycle pwm_o=0, all registers 0, and no shadow load occurs after reset release.

Source files
------------

// File: rtl/pwm_ctrl_pkg.sv
// Shared register map, bit positions and reset values for the PWM controller.
// Also holds the byte-lane merge used for every sel-qualified register write.
package pwm_ctrl_pkg;

   localparam logic [5:0] OFF_CTRL   = 6'h00;
   localparam logic [5:0] OFF_PRESC  = 6'h01;
   localparam logic [5:0] OFF_PERIOD = 6'h02;
   localparam logic [5:0] OFF_STATUS = 6'h03;
   localparam logic [5:0] OFF_DUTY0  = 6'h04;

   localparam int CTRL_EN     = 0;
   localparam int CTRL_IRQ_EN = 1;
   localparam int CTRL_UPD    = 2;

   localparam int STAT_PEND = 0;
   localparam int STAT_UPD  = 1;

   localparam logic        RST_FLAG  = 1'b0;
   localparam logic [15:0] RST_PRESC = 16'h0000;
   localparam logic [31:0] RST_WORD  = 32'h0000_0000;

   function automatic logic [31:0] merge_bytes(input logic [31:0] old_w,
                                               input logic [31:0] new_w,
                                               input logic [3:0]  sel);
      logic [31:0] r;
      r = old_w;
      for (int b = 0; b < 4; b++) begin
         if (sel[b]) r[8*b +: 8] = new_w[8*b +: 8];
      end
      return r;
   endfunction

endpackage

// File: rtl/pwm_timebase.sv
// Prescaler plus period counter; period_end is combinational on the wrapping cycle.
// Held at zero whenever en is low, no backpressure.
module pwm_timebase #(
   parameter int CW = 16
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          en,
   input  logic [15:0]   presc,
   input  logic [CW-1:0] per_act,
   output logic [CW-1:0] cnt,
   output logic          period_end
);

   logic [15:0]   pcnt_q, pcnt_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          tick;

   always_comb begin
      tick       = (pcnt_q == presc);
      period_end = en & tick & (cnt_q == per_act);
      pcnt_d     = pcnt_q;
      cnt_d      = cnt_q;
      if (!en) begin
         pcnt_d = '0;
         cnt_d  = '0;
      end else if (tick) begin
         pcnt_d = '0;
         cnt_d  = (cnt_q == per_act) ? '0 : cnt_q + CW'(1);
      end else begin
         // A PRESC lowered below pcnt lets pcnt run on to its natural 16-bit wrap.
         pcnt_d = pcnt_q + 16'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         pcnt_q <= '0;
         cnt_q  <= '0;
      end else begin
         pcnt_q <= pcnt_d;
         cnt_q  <= cnt_d;
      end
   end

   assign cnt = cnt_q;

endmodule

// File: rtl/pwm_ctrl.sv
// Wishbone-configured bank of PWM channels with double-buffered period/duty loaded at period end.
// Ack one cycle after a decoded strobe, never back-to-back; outputs combinational from registered state.
module pwm_ctrl
   import pwm_ctrl_pkg::*;
#(
   parameter int          NCH       = 4,
   parameter int          CW        = 16,
   parameter logic [31:0] BASE_ADDR = 32'h3000_0000
) (
   input  logic           wb_clk_i,
   input  logic           wb_rst_i,
   input  logic           wbs_cyc_i,
   input  logic           wbs_stb_i,
   input  logic           wbs_we_i,
   input  logic [3:0]     wbs_sel_i,
   input  logic [31:0]    wbs_adr_i,
   input  logic [31:0]    wbs_dat_i,
   output logic           wbs_ack_o,
   output logic [31:0]    wbs_dat_o,
   output logic [NCH-1:0] pwm_o,
   output logic [NCH-1:0] pwm_oeb,
   output logic           irq_o
);

   logic                    en_q, en_d, irq_en_q, irq_en_d, upd_q, upd_d;
   logic                    pend_q, pend_d, irq_q, irq_d, ack_q, ack_d;
   logic [15:0]             presc_q, presc_d;
   logic [CW-1:0]           per_sh_q, per_sh_d, per_act_q, per_act_d;
   logic [NCH-1:0][CW-1:0]  duty_sh_q, duty_sh_d, duty_act_q, duty_act_d;
   logic [31:0]             dat_q, dat_d;

   logic                    acc, wr, w1c, load;
   logic [5:0]              off;
   logic [31:0]             rd_word, mrg;
   logic [CW-1:0]           cnt;
   logic                    period_end;
   logic                    unused_adr;

   assign unused_adr = ^wbs_adr_i[1:0];
   assign off = wbs_adr_i[7:2];
   assign acc = wbs_cyc_i & wbs_stb_i & (wbs_adr_i[31:8] == BASE_ADDR[31:8]) & ~ack_q;
   assign wr  = acc & wbs_we_i;

   always_comb begin
      rd_word = RST_WORD;
      case (off)
         OFF_CTRL: begin
            rd_word[CTRL_EN]     = en_q;
            rd_word[CTRL_IRQ_EN] = irq_en_q;
            rd_word[CTRL_UPD]    = upd_q;
         end
         OFF_PRESC:  rd_word[15:0] = presc_q;
         OFF_PERIOD: rd_word[CW-1:0] = per_sh_q;
         OFF_STATUS: begin
            rd_word[STAT_PEND] = pend_q;
            rd_word[STAT_UPD]  = upd_q;
         end
         default: begin
            for (int i = 0; i < NCH; i++) begin
               if (off == OFF_DUTY0 + 6'(i)) rd_word[CW-1:0] = duty_sh_q[i];
            end
         end
      endcase
   end

   always_comb begin
      // Merging into the current read value keeps unselected byte lanes intact.
      mrg       = merge_bytes(rd_word, wbs_dat_i, wbs_sel_i);
      en_d      = en_q;
      irq_en_d  = irq_en_q;
      presc_d   = presc_q;
      per_sh_d  = per_sh_q;
      duty_sh_d = duty_sh_q;
      if (wr) begin
         case (off)
            OFF_CTRL: begin
               en_d     = mrg[CTRL_EN];
               irq_en_d = mrg[CTRL_IRQ_EN];
            end
            OFF_PRESC:  presc_d  = mrg[15:0];
            OFF_PERIOD: per_sh_d = mrg[CW-1:0];
            default: begin
               for (int i = 0; i < NCH; i++) begin
                  if (off == OFF_DUTY0 + 6'(i)) duty_sh_d[i] = mrg[CW-1:0];
               end
            end
         endcase
      end
   end

   pwm_timebase #(.CW(CW)) u_timebase (
      .clk        (wb_clk_i),
      .rst        (wb_rst_i),
      .en         (en_q & en_d),
      .presc      (presc_q),
      .per_act    (per_act_q),
      .cnt        (cnt),
      .period_end (period_end)
   );

   always_comb begin
      load       = period_end & upd_q;
      per_act_d  = per_act_q;
      duty_act_d = duty_act_q;
      // While disabled the active copies follow the shadows so enable starts on fresh values.
      if (!en_q || load) begin
         per_act_d  = per_sh_q;
         duty_act_d = duty_sh_q;
      end
      upd_d = upd_q;
      if (load) upd_d = 1'b0;
      if (wr && off == OFF_CTRL && wbs_sel_i[0] && wbs_dat_i[CTRL_UPD]) upd_d = 1'b1;
      w1c    = wr && off == OFF_STATUS && wbs_sel_i[0] && wbs_dat_i[STAT_PEND];
      pend_d = (pend_q & ~w1c) | period_end;
      irq_d  = pend_d & irq_en_d;
      ack_d  = acc;
      dat_d  = (acc && !wbs_we_i) ? rd_word : RST_WORD;
   end

   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         en_q       <= RST_FLAG;
         irq_en_q   <= RST_FLAG;
         upd_q      <= RST_FLAG;
         pend_q     <= RST_FLAG;
         irq_q      <= RST_FLAG;
         ack_q      <= RST_FLAG;
         presc_q    <= RST_PRESC;
         per_sh_q   <= '0;
         per_act_q  <= '0;
         duty_sh_q  <= '0;
         duty_act_q <= '0;
         dat_q      <= RST_WORD;
      end else begin
         en_q       <= en_d;
         irq_en_q   <= irq_en_d;
         upd_q      <= upd_d;
         pend_q     <= pend_d;
         irq_q      <= irq_d;
         ack_q      <= ack_d;
         presc_q    <= presc_d;
         per_sh_q   <= per_sh_d;
         per_act_q  <= per_act_d;
         duty_sh_q  <= duty_sh_d;
         duty_act_q <= duty_act_d;
         dat_q      <= dat_d;
      end
   end

   always_comb begin
      for (int i = 0; i < NCH; i++) pwm_o[i] = en_q & (cnt < duty_act_q[i]);
   end

   assign pwm_oeb   = ~{NCH{en_q}};
   assign irq_o     = irq_q;
   assign wbs_ack_o = ack_q;
   assign wbs_dat_o = dat_q;

endmodule

// File: tb/tb_pwm_ctrl.sv
// Randomised bus traffic against a time-since-period-start reference model, plus directed scenarios.
module tb_pwm_ctrl;

   localparam int          NCH  = 4;
   localparam int          CW   = 16;
   localparam logic [31:0] BASE = 32'h3000_0000;

   logic           clk = 1'b0;
   logic           wb_rst_i = 1'b1;
   logic           wbs_cyc_i = 1'b0, wbs_stb_i = 1'b0, wbs_we_i = 1'b0;
   logic [3:0]     wbs_sel_i = 4'h0;
   logic [31:0]    wbs_adr_i = '0, wbs_dat_i = '0;
   logic           wbs_ack_o, irq_o;
   logic [31:0]    wbs_dat_o;
   logic [NCH-1:0] pwm_o, pwm_oeb;

   pwm_ctrl #(.NCH(NCH), .CW(CW), .BASE_ADDR(BASE)) dut (
      .wb_clk_i(clk), .wb_rst_i(wb_rst_i),
      .wbs_cyc_i(wbs_cyc_i), .wbs_stb_i(wbs_stb_i), .wbs_we_i(wbs_we_i),
      .wbs_sel_i(wbs_sel_i), .wbs_adr_i(wbs_adr_i), .wbs_dat_i(wbs_dat_i),
      .wbs_ack_o(wbs_ack_o), .wbs_dat_o(wbs_dat_o),
      .pwm_o(pwm_o), .pwm_oeb(pwm_oeb), .irq_o(irq_o)
   );

   initial forever #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   bit chk_on = 1'b0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: registers plus t = cycles since the current period began.
   logic          m_en, m_irq_en, m_upd, m_pend, m_irq, m_ack;
   logic [15:0]   m_presc;
   logic [CW-1:0] m_per_sh, m_per_act;
   logic [CW-1:0] m_duty_sh[NCH], m_duty_act[NCH];
   logic [31:0]   m_dat;
   longint        m_t;

   function automatic logic [31:0] m_read(input logic [5:0] o);
      logic [31:0] r;
      r = '0;
      if (o == 0) r = {29'd0, m_upd, m_irq_en, m_en};
      else if (o == 1) r = {16'd0, m_presc};
      else if (o == 2) r = {16'd0, m_per_sh};
      else if (o == 3) r = {30'd0, m_upd, m_pend};
      else if (o >= 4 && o < 4 + NCH) r = {16'd0, m_duty_sh[o-4]};
      return r;
   endfunction

   initial begin : model
      bit acc, wr, run, pe, w1c, n_en, n_irq_en, n_upd, n_pend;
      logic [5:0] off;
      logic [31:0] rd, mrg;
      logic [15:0] n_presc;
      logic [CW-1:0] n_per_sh;
      logic [CW-1:0] n_duty_sh[NCH];
      longint plen;
      forever begin
         @(posedge clk);
         if (wb_rst_i) begin
            m_en = 0; m_irq_en = 0; m_upd = 0; m_pend = 0; m_irq = 0; m_ack = 0;
            m_presc = 0; m_per_sh = 0; m_per_act = 0; m_dat = 0; m_t = 0;
            for (int i = 0; i < NCH; i++) begin m_duty_sh[i] = 0; m_duty_act[i] = 0; end
         end else begin
            acc = wbs_cyc_i && wbs_stb_i && (wbs_adr_i[31:8] == BASE[31:8]) && !m_ack;
            off = wbs_adr_i[7:2];
            wr  = acc && wbs_we_i;
            rd  = m_read(off);
            mrg = rd;
            for (int b = 0; b < 4; b++) if (wbs_sel_i[b]) mrg[8*b +: 8] = wbs_dat_i[8*b +: 8];
            n_en = m_en; n_irq_en = m_irq_en; n_presc = m_presc; n_per_sh = m_per_sh;
            n_duty_sh = m_duty_sh;
            if (wr) begin
               if (off == 0) begin n_en = mrg[0]; n_irq_en = mrg[1]; end
               else if (off == 1) n_presc = mrg[15:0];
               else if (off == 2) n_per_sh = mrg[15:0];
               else if (off >= 4 && off < 4 + NCH) n_duty_sh[off-4] = mrg[15:0];
            end
            run  = m_en && n_en;
            plen = (longint'(m_per_act) + 1) * (longint'(m_presc) + 1);
            pe   = run && (m_t == plen - 1);
            w1c  = wr && off == 3 && wbs_sel_i[0] && wbs_dat_i[0];
            n_pend = (m_pend && !w1c) || pe;
            n_upd  = m_upd;
            if (!m_en || (pe && m_upd)) begin
               m_per_act  = m_per_sh;
               m_duty_act = m_duty_sh;
            end
            if (pe && m_upd) n_upd = 0;
            if (wr && off == 0 && wbs_sel_i[0] && wbs_dat_i[2]) n_upd = 1;
            m_t   = (run && !pe) ? m_t + 1 : 0;
            m_ack = acc;
            m_dat = (acc && !wbs_we_i) ? rd : 32'd0;
            m_irq = n_pend && n_irq_en;
            m_en = n_en; m_irq_en = n_irq_en; m_upd = n_upd; m_pend = n_pend;
            m_presc = n_presc; m_per_sh = n_per_sh; m_duty_sh = n_duty_sh;
         end
      end
   end

   initial begin : compare
      logic [NCH-1:0] e;
      forever begin
         @(negedge clk);
         if (chk_on) begin
            for (int i = 0; i < NCH; i++)
               e[i] = m_en && ((m_t / (longint'(m_presc) + 1)) < longint'(m_duty_act[i]));
            check("cmp_pwm_o", pwm_o, e);
            check("cmp_pwm_oeb", pwm_oeb, {NCH{~m_en}});
            check("cmp_irq_o", irq_o, m_irq);
            check("cmp_ack", wbs_ack_o, m_ack);
            check("cmp_dat_o", wbs_dat_o, m_dat);
         end
      end
   end

   task automatic wb(input bit we, input logic [31:0] adr, input logic [31:0] dat,
                     input logic [3:0] sel, output logic [31:0] rdat, output int lat);
      @(negedge clk);
      wbs_cyc_i = 1; wbs_stb_i = 1; wbs_we_i = we; wbs_adr_i = adr; wbs_dat_i = dat; wbs_sel_i = sel;
      lat = -1; rdat = '0;
      for (int k = 1; k <= 4; k++) begin
         @(negedge clk);
         if (wbs_ack_o === 1'b1) begin lat = k; rdat = wbs_dat_o; break; end
      end
      wbs_cyc_i = 0; wbs_stb_i = 0; wbs_we_i = 0;
   endtask

   task automatic bus_wr(input logic [7:0] boff, input logic [31:0] d, input logic [3:0] sel = 4'hF);
      logic [31:0] r; int lat;
      wb(1'b1, BASE + 32'(boff), d, sel, r, lat);
      check("wr_ack_latency", lat, 1);
   endtask

   task automatic bus_rd(input logic [7:0] boff, output logic [31:0] d);
      int lat;
      wb(1'b0, BASE + 32'(boff), 32'hDEAD_BEEF, 4'hF, d, lat);
      check("rd_ack_latency", lat, 1);
   endtask

   task automatic wait_t(input longint tv);
      bit ok;
      ok = 0;
      for (int k = 0; k < 300; k++) begin
         if (m_t == tv) begin ok = 1; break; end
         @(negedge clk);
      end
      check("wait_period_phase", ok, 1);
   endtask

   task automatic count_high(input int ch, input int ncyc, output int h);
      h = 0;
      for (int k = 0; k < ncyc; k++) begin
         h += int'(pwm_o[ch]);
         @(negedge clk);
      end
   endtask

   initial begin : watchdog
      #2_000_000;
      $display("FAIL watchdog timeout");
      $fatal(1);
   end

   initial begin : stim
      logic [31:0] r;
      logic [7:0]  offs[9];
      int h0, h1, h2, first, lat;
      offs = '{8'h00, 8'h04, 8'h08, 8'h0C, 8'h10, 8'h14, 8'h18, 8'h1C, 8'h40};
      repeat (2) @(posedge clk);
      chk_on = 1;
      @(negedge clk);
      wb_rst_i = 0;

      // Reset state
      check("rst_pwm_oeb", pwm_oeb, 4'hF);
      check("rst_pwm_o", pwm_o, 4'h0);
      for (int i = 0; i < 9; i++) begin
         bus_rd(offs[i], r);
         check("rst_read_zero", r, 32'h0);
      end

      // Basic duty patterns with PRESC=0, PERIOD=9
      bus_wr(8'h04, 0); bus_wr(8'h08, 9);
      bus_wr(8'h10, 3); bus_wr(8'h14, 0); bus_wr(8'h18, 10);
      bus_wr(8'h00, 32'h1);
      check("en_first_cycle_pwm0", pwm_o[0], 1);
      count_high(0, 20, h0);
      check("duty3_high_count", h0, 6);
      count_high(1, 20, h1);
      check("duty0_high_count", h1, 0);
      count_high(2, 20, h2);
      check("duty_gt_period_high_count", h2, 20);

      // Double-buffered duty update
      bus_wr(8'h10, 7);
      count_high(0, 10, h0);
      check("shadow_not_yet_active", h0, 3);
      wait_t(2);
      bus_wr(8'h00, 32'h5);
      bus_rd(8'h0C, r);
      check("status_upd_pending", r[1], 1);
      repeat (15) @(negedge clk);
      bus_rd(8'h0C, r);
      check("status_upd_cleared", r[1], 0);
      count_high(0, 10, h0);
      check("new_duty_high_count", h0, 7);

      // Interrupt timing and W1C
      bus_wr(8'h00, 0); bus_wr(8'h0C, 1); bus_wr(8'h04, 2); bus_wr(8'h08, 4);
      bus_wr(8'h00, 32'h3);
      first = -1;
      for (int k = 0; k < 40; k++) begin
         if (irq_o === 1'b1) begin first = k; break; end
         @(negedge clk);
      end
      check("irq_first_cycle", first, 15);
      bus_wr(8'h0C, 1);
      check("irq_after_w1c", irq_o, 0);
      wait_t(13);
      bus_wr(8'h0C, 1);
      check("irq_w1c_on_period_end", irq_o, 1);
      bus_rd(8'h0C, r);
      check("pend_set_wins", r[0], 1);

      // Byte enables and decode
      bus_wr(8'h10, 32'hAABB_CCDD, 4'b0001);
      bus_rd(8'h10, r);
      check("sel_byte0", r, 32'h0000_00DD);
      bus_wr(8'h14, 32'h1234_5678, 4'b0010);
      bus_rd(8'h14, r);
      check("sel_byte1", r, 32'h0000_5600);
      wb(1'b0, BASE + 32'h100, 0, 4'hF, r, lat);
      check("nomatch_read_no_ack", lat, -1);
      wb(1'b1, BASE + 32'h100, 0, 4'hF, r, lat);
      check("nomatch_write_no_ack", lat, -1);
      check("nomatch_write_no_effect", pwm_oeb, 4'h0);

      // Reset mid-period with an update pending
      bus_wr(8'h00, 0); bus_wr(8'h04, 0); bus_wr(8'h08, 200); bus_wr(8'h10, 100);
      bus_wr(8'h00, 1); bus_wr(8'h10, 50); bus_wr(8'h00, 5);
      bus_rd(8'h0C, r);
      check("pre_reset_upd_pending", r[1], 1);
      wb_rst_i = 1;
      @(negedge clk);
      check("midrst_pwm_o", pwm_o, 4'h0);
      check("midrst_pwm_oeb", pwm_oeb, 4'hF);
      wb_rst_i = 0;
      for (int i = 0; i < 9; i++) begin
         bus_rd(offs[i], r);
         check("post_rst_read_zero", r, 32'h0);
      end
      bus_wr(8'h00, 1);
      repeat (5) @(negedge clk);
      check("post_rst_no_load", pwm_o, 4'h0);

      // Randomised traffic
      for (int n = 0; n < 300; n++) begin
         logic [7:0] boff; logic [31:0] d; logic [3:0] sel; bit we, bad;
         int pick;
         pick = $urandom_range(0, 9);
         we   = ($urandom_range(0, 3) != 0);
         sel  = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'hF;
         bad  = ($urandom_range(0, 19) == 0);
         d    = $urandom;
         case (pick)
            0: begin boff = 8'h00;
                  d = {29'd0, 1'($urandom), 1'($urandom), 1'($urandom_range(0, 4) != 0)}; end
            1: begin boff = m_en ? 8'h0C : 8'h04; d = m_en ? d : 32'($urandom_range(0, 3)); end
            2: begin boff = 8'h08; d = 32'($urandom_range(0, 12)); end
            3: boff = 8'h0C;
            4, 5, 6, 7: begin boff = 8'h10 + 8'(4 * (pick - 4)); d = 32'($urandom_range(0, 15)); end
            8: boff = 8'h24;
            default: boff = 8'h3C;
         endcase
         wb(we, (bad ? BASE + 32'h100 : BASE) + 32'(boff), d, sel, r, lat);
         check(bad ? "rand_nomatch_ack" : "rand_ack_latency", lat, bad ? -1 : 1);
         repeat ($urandom_range(0, 6)) @(negedge clk);
      end

      @(negedge clk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
